// File: rtl/pon_burst_pkg.sv
// Shared types and helpers for the PON upstream burst sequencer.
// Stats counters are built only when PON_BURST_SEQ_STATS_EN is defined.
package pon_burst_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int MIN_GAP_DEF = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    BURST    = 2'd2,
    GAP      = 2'd3
  } state_t;

  // Sum is taken two bits wider than the widest field so it can never wrap.
  function automatic logic cfg_valid(input logic [63:0] pre,
                                     input logic [63:0] burst,
                                     input logic [63:0] period,
                                     input logic [63:0] min_gap);
    logic [65:0] need;
    need = 66'(pre) + 66'(burst) + 66'(min_gap);
    return (burst != 64'd0) && (need <= 66'(period));
  endfunction

endpackage

// File: rtl/pon_burst_cfg_shadow.sv
// Shadow copy of the per-period configuration, latched at every period start,
// with precomputed phase boundaries and a registered config-error flag.
module pon_burst_cfg_shadow
  import pon_burst_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_i,
  input  logic [CNT_W-1:0] pre_i,
  input  logic [CNT_W-1:0] burst_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             valid_now_o,
  output logic [CNT_W-1:0] pre_o,
  output logic [CNT_W:0]   burst_end_o,
  output logic [CNT_W-1:0] period_last_o,
  output logic             cfg_err_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W:0]   burst_end_q, burst_end_d;
  logic [CNT_W-1:0] period_last_q, period_last_d;
  logic             cfg_err_q, cfg_err_d;

  assign valid_now_o = cfg_valid(64'(pre_i), 64'(burst_i), 64'(period_i),
                                 64'(MIN_GAP));

  always_comb begin
    pre_d         = pre_q;
    burst_end_d   = burst_end_q;
    period_last_d = period_last_q;
    cfg_err_d     = cfg_err_q;
    if (latch_i) begin
      pre_d         = pre_i;
      burst_end_d   = {1'b0, pre_i} + {1'b0, burst_i};
      // A zero period still runs one gap cycle so the FSM always makes progress.
      period_last_d = (period_i == '0) ? '0 : (period_i - ONE);
      cfg_err_d     = ~valid_now_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q         <= '0;
      burst_end_q   <= '0;
      period_last_q <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      burst_end_q   <= burst_end_d;
      period_last_q <= period_last_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign pre_o         = pre_q;
  assign burst_end_o   = burst_end_q;
  assign period_last_o = period_last_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: rtl/pon_burst_sequencer.sv
// Upstream burst scheduler: sequences PREAMBLE / BURST / GAP per period.
// Define PON_BURST_SEQ_STATS_EN to build the burst and cfg-error counters.
module pon_burst_sequencer
  import pon_burst_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] preamble_length,
  input  logic [CNT_W-1:0] burst_length,
  input  logic [CNT_W-1:0] burst_period,
  input  logic             stats_clear,
  output logic             tx_enable,
  output logic             preamble_sel,
  output logic             data_req,
  output logic             burst_start,
  output logic             period_start,
  output logic             cfg_error,
  output logic             busy,
  output logic [31:0]      burst_count,
  output logic [15:0]      cfg_error_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             latch, end_period, burst_done;
  logic             valid_now;
  logic [CNT_W-1:0] sh_pre, sh_period_last;
  logic [CNT_W:0]   sh_burst_end;

  logic tx_enable_q, preamble_sel_q, data_req_q, burst_start_q;
  logic period_start_q, busy_q;

  pon_burst_cfg_shadow #(
    .CNT_W   (CNT_W),
    .MIN_GAP (MIN_GAP)
  ) u_shadow (
    .clk           (clk),
    .rst           (rst),
    .latch_i       (latch),
    .pre_i         (preamble_length),
    .burst_i       (burst_length),
    .period_i      (burst_period),
    .valid_now_o   (valid_now),
    .pre_o         (sh_pre),
    .burst_end_o   (sh_burst_end),
    .period_last_o (sh_period_last),
    .cfg_err_o     (cfg_error)
  );

  assign cnt_nxt = cnt_q + ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    end_period = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) latch = 1'b1;
      end
      PREAMBLE: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt == sh_pre) state_d = BURST;
      end
      BURST: begin
        cnt_d = cnt_nxt;
        if ({1'b0, cnt_nxt} == sh_burst_end) begin
          burst_done = 1'b1;
          // With MIN_GAP of 0 a burst may end exactly on the period boundary.
          if (cnt_q == sh_period_last) end_period = 1'b1;
          else                         state_d    = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_nxt;
        if (cnt_q == sh_period_last) end_period = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (end_period) begin
      if (enable) begin
        latch = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    if (latch) begin
      cnt_d = '0;
      if (!valid_now)                 state_d = GAP;
      else if (preamble_length == '0) state_d = BURST;
      else                            state_d = PREAMBLE;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tx_enable_q    <= 1'b0;
      preamble_sel_q <= 1'b0;
      data_req_q     <= 1'b0;
      burst_start_q  <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_enable_q    <= (state_d == PREAMBLE) || (state_d == BURST);
      preamble_sel_q <= (state_d == PREAMBLE);
      data_req_q     <= (state_d == BURST);
      burst_start_q  <= (state_d == BURST) && ((state_q != BURST) || latch);
      period_start_q <= latch;
      busy_q         <= (state_d != IDLE);
    end
  end

  assign tx_enable    = tx_enable_q;
  assign preamble_sel = preamble_sel_q;
  assign data_req     = data_req_q;
  assign burst_start  = burst_start_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;

`ifdef PON_BURST_SEQ_STATS_EN
  logic [31:0] burst_count_q;
  logic [15:0] cfg_err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || stats_clear) begin
      burst_count_q <= '0;
      cfg_err_cnt_q <= '0;
    end else begin
      if (burst_done)            burst_count_q <= burst_count_q + 32'd1;
      if (latch && !valid_now)   cfg_err_cnt_q <= cfg_err_cnt_q + 16'd1;
    end
  end

  assign burst_count     = burst_count_q;
  assign cfg_error_count = cfg_err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = stats_clear ^ burst_done;
  assign burst_count     = '0;
  assign cfg_error_count = '0;
`endif

endmodule

// File: tb/tb_pon_burst_sequencer.sv
// Directed bench for pon_burst_sequencer; stats expectations follow
// whether PON_BURST_SEQ_STATS_EN is defined in the build.
module tb_pon_burst_sequencer;

`ifdef PON_BURST_SEQ_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, stats_clear;
  logic [31:0] preamble_length, burst_length, burst_period;
  logic        tx_enable, preamble_sel, data_req, burst_start, period_start;
  logic        cfg_error, busy;
  logic [31:0] burst_count;
  logic [15:0] cfg_error_count;

  int total = 0;
  int bad   = 0;

  pon_burst_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .preamble_length (preamble_length),
    .burst_length    (burst_length),
    .burst_period    (burst_period),
    .stats_clear     (stats_clear),
    .tx_enable       (tx_enable),
    .preamble_sel    (preamble_sel),
    .data_req        (data_req),
    .burst_start     (burst_start),
    .period_start    (period_start),
    .cfg_error       (cfg_error),
    .busy            (busy),
    .burst_count     (burst_count),
    .cfg_error_count (cfg_error_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_cfg(input int pre, input int bl, input int per);
    preamble_length = pre;
    burst_length    = bl;
    burst_period    = per;
  endtask

  // {period_start, preamble_sel, data_req, burst_start, tx_enable, cfg_error, busy}
  function automatic logic [31:0] dut_vec();
    return {25'd0, period_start, preamble_sel, data_req, burst_start,
            tx_enable, cfg_error, busy};
  endfunction

  // Expected strobes for cycle k of a valid period.
  function automatic logic [31:0] exp_vec(int k, int pre, int bl);
    logic ps, psel, dr, bs, tx;
    ps   = (k == 0);
    psel = (k < pre);
    dr   = (k >= pre) && (k < pre + bl);
    bs   = (k == pre);
    tx   = (k < pre + bl);
    return {25'd0, ps, psel, dr, bs, tx, 1'b0, 1'b1};
  endfunction

  function automatic logic [31:0] s32(int v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; stats_clear = 1'b0;
    set_cfg(4, 8, 20);
    tick(2);
    check("rst_vec", dut_vec(), 32'd0);
    check("rst_bcnt", burst_count, 32'd0);
    check("rst_ecnt", 32'(cfg_error_count), 32'd0);

    // nominal 4/8/20, enable held
    rst = 1'b0; enable = 1'b1;
    tick();
    for (int k = 0; k < 60; k++) begin
      check($sformatf("nom_k%0d", k), dut_vec(), exp_vec(k % 20, 4, 8));
      tick();
    end
    check("nom_bcnt3", burst_count, s32(3));

    // stats_clear on the last burst cycle of period 4
    tick(11);
    check("clr_last_burst", 32'(data_req), 32'd1);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    check("clr_wins", burst_count, s32(0));
    check("clr_gap", 32'(tx_enable), 32'd0);
    set_cfg(0, 5, 10);
    tick(8);

    // zero preamble 0/5/10; invalid config queued mid-period
    for (int k = 0; k < 20; k++) begin
      check($sformatf("zp_k%0d", k), dut_vec(), exp_vec(k % 10, 0, 5));
      if (k == 15) set_cfg(10, 10, 20);
      tick();
    end
    check("zp_bcnt2", burst_count, s32(2));

    // invalid 10/10/20, fixed to 10/9/20 during the second period
    for (int k = 0; k < 40; k++) begin
      check($sformatf("bad_k%0d", k), dut_vec(), {25'd0, k % 20 == 0, 6'b000011});
      if (k % 20 == 0)
        check($sformatf("bad_ecnt_k%0d", k), 32'(cfg_error_count), s32(1 + k / 20));
      if (k == 25) burst_length = 9;
      tick();
    end
    check("fix_vec0", dut_vec(), exp_vec(0, 10, 9));
    check("fix_ecnt", 32'(cfg_error_count), s32(2));
    set_cfg(4, 8, 20);
    tick(10);
    check("fix_vec10", dut_vec(), exp_vec(10, 10, 9));
    tick(10);
    check("p48_vec0", dut_vec(), exp_vec(0, 4, 8));
    check("p48_bcnt", burst_count, s32(3));

    // enable drop + burst_length change at cycle 6
    tick(6);
    enable = 1'b0;
    burst_length = 2;
    for (int k = 6; k < 20; k++) begin
      check($sformatf("drop_k%0d", k), dut_vec(), exp_vec(k, 4, 8));
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      check($sformatf("idle_k%0d", k), dut_vec(), 32'd0);
      tick();
    end
    check("drop_bcnt", burst_count, s32(4));

    // reset mid-burst at cycle 7
    set_cfg(4, 8, 20);
    enable = 1'b1;
    tick();
    check("rb_vec0", dut_vec(), exp_vec(0, 4, 8));
    tick(7);
    check("rb_vec7", dut_vec(), exp_vec(7, 4, 8));
    check("rb_bcnt_pre", burst_count, s32(4));
    rst = 1'b1;
    tick();
    check("rb_vec_rst", dut_vec(), 32'd0);
    check("rb_bcnt_rst", burst_count, 32'd0);
    check("rb_ecnt_rst", 32'(cfg_error_count), 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    tick(3);
    check("rb_idle", dut_vec(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
